spi_reg_peripheral: RTL and testbench

- Write-only SPI (mode 0) slave plus register bank. Sits directly upstream of the PWM peripheral and drives its five control bytes: output enables, PWM enables and duty cycle.
- SCLK, COPI and nCS arrive asynchronously on ui_in[0], ui_in[1] and ui_in[2]. They are synchronised into the clk domain and decoded as 16-bit frames.
- Valid write frames update one register when nCS deasserts.

---
 rtl/spi_reg_peripheral.sv | 148 ++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 slave feeding a five-byte control register bank.
// Raw SPI pins are synchronised into clk. Each 16-bit frame (R/W, 7-bit
// address, 8-bit data) is evaluated when nCS deasserts. A good write
// frame then updates one register one clock later.
module spi_reg_peripheral #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

   typedef enum logic {IDLE, RECV} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
   logic                   sclk_d, ncs_d;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_rise, ncs_fall, ncs_rise;
   logic [15:0]            frame_sr;
   logic [4:0]             bit_cnt;
   logic                   frame_clr, bit_shift, frame_eval;
   logic                   vld_p1, err_p1;
   logic [6:0]             wr_addr_p1;
   logic [7:0]             wr_data_p1;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign copi_s    = copi_sync[SYNC_STAGES-1];
   assign ncs_s     = ncs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign ncs_fall  = ~ncs_s & ncs_d;
   assign ncs_rise  = ncs_s & ~ncs_d;

   // Synchronisers plus one delay flop per edge-detected signal; idle values on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
         sclk_d    <= 1'b0;
         ncs_d     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
         sclk_d    <= sclk_s;
         ncs_d     <= ncs_s;
      end
   end

   // Frame FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Frame FSM next state: a falling nCS always (re)starts a frame, a rising nCS ends it
   always_comb begin
      state_d    = state_q;
      frame_clr  = 1'b0;
      bit_shift  = 1'b0;
      frame_eval = 1'b0;
      case (state_q)
         IDLE: begin
            if (ncs_fall) begin
               frame_clr = 1'b1;
               state_d   = RECV;
            end
         end
         RECV: begin
            if (ncs_fall) begin
               frame_clr = 1'b1;
            end else if (ncs_rise) begin
               frame_eval = 1'b1;
               state_d    = IDLE;
            end else if (sclk_rise && !ncs_s) begin
               bit_shift = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p0 -> p1: shift/count bits, and decide commit or error at frame end
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_sr <= '0;
         bit_cnt  <= '0;
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
      end else begin
         vld_p1 <= frame_eval && (bit_cnt == 5'd16) && frame_sr[15] && (frame_sr[14:8] <= MAX_A);
         err_p1 <= frame_eval && ((bit_cnt != 5'd16) || (frame_sr[15] && (frame_sr[14:8] > MAX_A)));
         if (frame_clr) begin
            frame_sr <= '0;
            bit_cnt  <= '0;
         end else if (bit_shift) begin
            frame_sr <= {frame_sr[14:0], copi_s};
            bit_cnt  <= (bit_cnt == 5'd17) ? 5'd17 : bit_cnt + 5'd1;
         end
      end
   end

   // Stage p1 data: address and data captured alongside vld_p1
   always_ff @(posedge clk) begin
      wr_addr_p1 <= frame_sr[14:8];
      wr_data_p1 <= frame_sr[7:0];
   end

   // Stage p1 -> outputs: register bank update and one-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
         wr_strobe       <= 1'b0;
         frame_err       <= 1'b0;
      end else begin
         wr_strobe <= vld_p1;
         frame_err <= err_p1;
         if (vld_p1) begin
            case (wr_addr_p1)
               7'd0:    en_reg_out_7_0  <= wr_data_p1;
               7'd1:    en_reg_out_15_8 <= wr_data_p1;
               7'd2:    en_reg_pwm_7_0  <= wr_data_p1;
               7'd3:    en_reg_pwm_15_8 <= wr_data_p1;
               7'd4:    pwm_duty_cycle  <= wr_data_p1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Bench for spi_reg_peripheral: directed vector table, hand-written
// latency and reset sequences, and randomized frames against a frame-level model.
module tb_spi_reg_peripheral;

   localparam int SYNC = 2;

   logic       clk, rst, sclk, copi, ncs;
   logic [7:0] r0, r1, r2, r3, r4;
   logic       wr_strobe, frame_err;

   spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .copi            (copi),
      .ncs             (ncs),
      .en_reg_out_7_0  (r0),
      .en_reg_out_15_8 (r1),
      .en_reg_pwm_7_0  (r2),
      .en_reg_pwm_15_8 (r3),
      .pwm_duty_cycle  (r4),
      .wr_strobe       (wr_strobe),
      .frame_err       (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_wr   = 0;
   int n_err  = 0;

   // pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (wr_strobe) n_wr = n_wr + 1;
      if (frame_err) n_err = n_err + 1;
   end

   // frame-level reference: register contents and cumulative pulse counts
   logic [7:0] mdl [5];
   int m_wr  = 0;
   int m_err = 0;

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      int          exp_wr;
      int          exp_err;
      int          chk_addr;
      logic [7:0]  exp_val;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dut_reg(input int a);
      case (a)
         0: return r0;
         1: return r1;
         2: return r2;
         3: return r3;
         default: return r4;
      endcase
   endfunction

   task automatic model_apply(input logic [31:0] bits, input int nbits);
      logic [15:0] f;
      int          addr;
      f    = bits[15:0];
      addr = int'(f[14:8]);
      if (nbits == 16 && f[15] && addr <= 4) begin
         mdl[addr] = f[7:0];
         m_wr++;
      end else if (nbits != 16 || (f[15] && addr > 4)) begin
         m_err++;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
   endtask

   task automatic check_model(input string tag);
      for (int i = 0; i < 5; i++) check($sformatf("%s_reg%0d", tag, i), dut_reg(i), mdl[i]);
      check({tag, "_nwr"}, n_wr, m_wr);
      check({tag, "_nerr"}, n_err, m_err);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // sclk = clk/8, MSB first, data set up during the low phase
   task automatic shift_bits(input logic [31:0] bits, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = bits[i];
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
   endtask

   // complete frame followed by one sclk period of nCS high
   task automatic send_frame(input logic [31:0] bits, input int nbits);
      ncs = 1'b0;
      tick(4);
      shift_bits(bits, nbits);
      tick(4);
      ncs = 1'b1;
      tick(8);
   endtask

   task automatic sclk_noise(input int n);
      for (int i = 0; i < n; i++) begin
         copi = 1'($urandom);
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 5; i++) check($sformatf("%s_reg%0d", tag, i), dut_reg(i), 0);
      check({tag, "_strobe"}, wr_strobe, 0);
      check({tag, "_err"}, frame_err, 0);
   endtask

   initial begin
      int w0, e0;
      logic [31:0] bits;
      logic [15:0] f;
      int nb;

      rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
      model_clear();
      tick(3);
      check_all_zero("por");
      rst = 1'b0;
      tick(4);

      // single write with exact commit latency
      ncs = 1'b0;
      tick(4);
      shift_bits(32'h8055, 16);
      tick(4);
      w0 = n_wr;
      ncs = 1'b1;
      for (int i = 0; i <= SYNC; i++) begin
         tick(1);
         check($sformatf("lat_early%0d_reg0", i), r0, 0);
         check($sformatf("lat_early%0d_strobe", i), wr_strobe, 0);
      end
      tick(1);
      check("lat_reg0", r0, 8'h55);
      check("lat_strobe", wr_strobe, 1);
      tick(1);
      check("lat_strobe_off", wr_strobe, 0);
      tick(8);
      model_apply(32'h8055, 16);
      check("lat_nwr", n_wr - w0, 1);
      check_model("single");

      vecs[0] = '{32'h81F0,  16, 1, 0, 1, 8'hF0};
      vecs[1] = '{32'h820F,  16, 1, 0, 2, 8'h0F};
      vecs[2] = '{32'h83AA,  16, 1, 0, 3, 8'hAA};
      vecs[3] = '{32'h8480,  16, 1, 0, 4, 8'h80};
      vecs[4] = '{32'h85FF,  16, 0, 1, 0, 8'h55};
      vecs[5] = '{32'h4219,  15, 0, 1, 4, 8'h80};
      vecs[6] = '{32'h10867, 17, 0, 1, 4, 8'h80};
      vecs[7] = '{32'h0277,  16, 0, 0, 2, 8'h0F};

      for (int v = 0; v < 8; v++) begin
         w0 = n_wr;
         e0 = n_err;
         send_frame(vecs[v].bits, vecs[v].nbits);
         model_apply(vecs[v].bits, vecs[v].nbits);
         check($sformatf("vec%0d_wr", v), n_wr - w0, vecs[v].exp_wr);
         check($sformatf("vec%0d_err", v), n_err - e0, vecs[v].exp_err);
         check($sformatf("vec%0d_reg", v), dut_reg(vecs[v].chk_addr), vecs[v].exp_val);
         check_model($sformatf("vec%0d", v));
      end

      // sclk activity with nCS high must not disturb a following frame
      sclk_noise(5);
      send_frame(32'h8133, 16);
      model_apply(32'h8133, 16);
      check_model("noise");

      // reset while idle
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      check_all_zero("idle_rst");
      model_clear();
      tick(4);

      // reset mid-frame: partial frame discarded, nCS raised as reset releases
      w0 = n_wr;
      e0 = n_err;
      ncs = 1'b0;
      tick(4);
      shift_bits(32'h105, 9);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      ncs = 1'b1;
      tick(12);
      check("mid_rst_reg2", r2, 0);
      check("mid_rst_wr", n_wr - w0, 0);
      check("mid_rst_err", n_err - e0, 0);
      send_frame(32'h8299, 16);
      model_apply(32'h8299, 16);
      check("after_rst_reg2", r2, 8'h99);
      check_model("after_rst");

      // randomized frames against the reference model
      for (int t = 0; t < 40; t++) begin
         logic rw;
         int   r;
         rw = ($urandom_range(0, 3) != 0);
         f  = {rw, rw ? 7'($urandom_range(0, 6)) : 7'($urandom_range(0, 4)), 8'($urandom)};
         r  = $urandom_range(0, 9);
         nb = (r < 7) ? 16 : ((r == 7) ? 15 : ((r == 8) ? 17 : 18));
         if (nb == 16)      bits = {16'h0, f};
         else if (nb < 16)  bits = {16'h0, f} >> (16 - nb);
         else               bits = ({16'h0, f} << (nb - 16)) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) sclk_noise(2);
         send_frame(bits, nb);
         model_apply(bits, nb);
         check_model($sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
